lbp_mem_arb: RTL and testbench

LBP_MEM_ARB -- requirements
Module: lbp_mem_arb

---
 rtl/lbp_pkg.sv | 14 +
 rtl/lbp_mem_arb_rr_pick.sv | 34 +++
 rtl/lbp_mem_arb.sv | 129 ++++++++++++
 tb/tb_lbp_mem_arb.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/lbp_pkg.sv
// Shared definitions for the LBP memory arbiter.
//   LBP_AW / LBP_DW : default memory address / data widths
//   arb_mode_e      : arbitration mode encodings (static select, round-robin)
package lbp_pkg;

    localparam int LBP_AW = 12;
    localparam int LBP_DW = 8;

    typedef enum logic {
        ARB_STATIC = 1'b0,
        ARB_RR     = 1'b1
    } arb_mode_e;

endpackage

// File: rtl/lbp_mem_arb_rr_pick.sv
// rr_pick: round-robin priority selector.
//   req : request vector, one bit per port
//   ptr : highest-priority port index for this cycle
//   gnt : one-hot winner; the first requester found scanning
//         ptr, ptr+1, ... modulo N. All zero when nothing requests.
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    localparam int unsigned NU = N;

    logic found;

    // Outer loop walks priority distance from ptr; the inner loop only
    // matches the single port sitting at that distance.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NU; k++) begin
            for (int unsigned i = 0; i < NU; i++) begin
                if (!found && req[i] && (((32'(ptr) + k) % NU) == i)) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/lbp_mem_arb.sv
// lbp_mem_arb: arbitrates NPORT requesters onto a single LBP memory port.
//   clk, rst_n        : clock, asynchronous active-low reset
//   arb_mode, sel     : 0 = only port 'sel' eligible, 1 = round-robin
//   req/wen/addr/wdata: per-port requests (port i at slice i*W +: W)
//   gnt               : one-hot grant, accepted in the same cycle
//   rvalid/rdata      : per-port read return, RD_LAT cycles after grant
//   lbp_*             : memory request side; lbp_rdata is the return data
module lbp_mem_arb
    import lbp_pkg::*;
#(
    parameter int NPORT  = 2,
    parameter int AW     = LBP_AW,
    parameter int DW     = LBP_DW,
    parameter int RD_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    arb_mode,
    input  logic [$clog2(NPORT)-1:0] sel,
    input  logic [NPORT-1:0]        req,
    input  logic [NPORT-1:0]        wen,
    input  logic [NPORT*AW-1:0]     addr,
    input  logic [NPORT*DW-1:0]     wdata,
    output logic [NPORT-1:0]        gnt,
    output logic [NPORT-1:0]        rvalid,
    output logic [NPORT*DW-1:0]     rdata,
    output logic [AW-1:0]           lbp_addr,
    output logic                    lbp_wen,
    output logic [DW-1:0]           lbp_wdata,
    output logic                    lbp_ren,
    input  logic [DW-1:0]           lbp_rdata
);

    localparam int SW = $clog2(NPORT);
    localparam int unsigned NU = NPORT;
    localparam int unsigned LU = RD_LAT;

    logic [SW-1:0]    ptr;
    logic [NPORT-1:0] rr_gnt;
    logic [NPORT-1:0] st_gnt;
    logic             any_gnt;
    logic [SW-1:0]    win;
    logic             win_wen;

    // Return pipeline: valid flag and originating port per stage.
    logic             rd_vld [RD_LAT];
    logic [SW-1:0]    rd_id  [RD_LAT];

    rr_pick #(
        .N  (NPORT),
        .PW (SW)
    ) u_rr_pick (
        .req (req),
        .ptr (ptr),
        .gnt (rr_gnt)
    );

    always_comb begin
        st_gnt = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            if (sel == SW'(i)) begin
                st_gnt[i] = req[i];
            end
        end
    end

    // Grant is forced low while reset is held so the memory side stays idle.
    always_comb begin
        gnt = '0;
        if (rst_n) begin
            gnt = (arb_mode_e'(arb_mode) == ARB_RR) ? rr_gnt : st_gnt;
        end
    end

    always_comb begin
        win       = '0;
        win_wen   = 1'b0;
        lbp_addr  = '0;
        lbp_wdata = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            if (gnt[i]) begin
                win       = SW'(i);
                win_wen   = wen[i];
                lbp_addr  = addr[i*AW +: AW];
                lbp_wdata = wen[i] ? wdata[i*DW +: DW] : '0;
            end
        end
    end

    assign any_gnt = |gnt;
    assign lbp_wen = any_gnt & win_wen;
    assign lbp_ren = any_gnt & ~win_wen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (any_gnt) begin
            ptr <= (win == SW'(NPORT - 1)) ? '0 : win + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < LU; s++) begin
                rd_vld[s] <= 1'b0;
                rd_id[s]  <= '0;
            end
        end else begin
            rd_vld[0] <= lbp_ren;
            rd_id[0]  <= win;
            for (int unsigned s = 1; s < LU; s++) begin
                rd_vld[s] <= rd_vld[s-1];
                rd_id[s]  <= rd_id[s-1];
            end
        end
    end

    always_comb begin
        rvalid = '0;
        rdata  = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            if (rd_vld[RD_LAT-1] && (rd_id[RD_LAT-1] == SW'(i))) begin
                rvalid[i]          = 1'b1;
                rdata[i*DW +: DW]  = lbp_rdata;
            end
        end
    end

endmodule

// File: tb/tb_lbp_mem_arb.sv
// Self-checking bench for lbp_mem_arb (NPORT=2, AW=12, DW=8, RD_LAT=1).
// A behavioural model (winner choice by priority scan, pending-read queue,
// reference memory) predicts every output each cycle.
module tb_lbp_mem_arb;

    localparam int NPORT  = 2;
    localparam int AW     = 12;
    localparam int DW     = 8;
    localparam int RD_LAT = 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 arb_mode = 1'b0;
    logic [0:0]           sel = '0;
    logic [NPORT-1:0]     req = '0;
    logic [NPORT-1:0]     wen = '0;
    logic [NPORT*AW-1:0]  addr = '0;
    logic [NPORT*DW-1:0]  wdata = '0;
    logic [NPORT-1:0]     gnt;
    logic [NPORT-1:0]     rvalid;
    logic [NPORT*DW-1:0]  rdata;
    logic [AW-1:0]        lbp_addr;
    logic                 lbp_wen;
    logic [DW-1:0]        lbp_wdata;
    logic                 lbp_ren;
    logic [DW-1:0]        lbp_rdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lbp_mem_arb #(
        .NPORT  (NPORT),
        .AW     (AW),
        .DW     (DW),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arb_mode  (arb_mode),
        .sel       (sel),
        .req       (req),
        .wen       (wen),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .lbp_addr  (lbp_addr),
        .lbp_wen   (lbp_wen),
        .lbp_wdata (lbp_wdata),
        .lbp_ren   (lbp_ren),
        .lbp_rdata (lbp_rdata)
    );

    // Memory attached to the bus, one-cycle read latency.
    logic [DW-1:0] bus_mem [4096];
    always @(posedge clk) begin
        if (lbp_wen) bus_mem[lbp_addr] <= lbp_wdata;
        lbp_rdata <= bus_mem[lbp_addr];
    end

    // Reference model state.
    typedef struct {
        int            due;
        int            port;
        logic [DW-1:0] data;
    } rd_t;

    logic [DW-1:0] ref_mem [4096];
    rd_t           pend[$];
    int            ref_ptr = 0;
    int            cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, check everything against the model,
    // then advance the model at the rising edge.
    // want_gnt / want_rv: hard-coded expectations from the scenario (-1 = none).
    task automatic step(input logic mode, input int s, input logic [1:0] r,
                        input logic [1:0] w, input logic [11:0] a0, input logic [11:0] a1,
                        input logic [7:0] d0, input logic [7:0] d1, input string tag,
                        input int want_gnt, input int want_rv);
        int            win;
        int            p;
        logic [1:0]    e_gnt;
        logic [1:0]    e_rv;
        logic [15:0]   e_rd;
        logic [11:0]   e_addr;
        logic          e_w;
        logic [7:0]    e_wd;
        @(negedge clk);
        arb_mode = mode;
        sel      = s[0:0];
        req      = r;
        wen      = w;
        addr     = {a1, a0};
        wdata    = {d1, d0};
        #1;
        win = -1;
        if (mode == 1'b0) begin
            if ((s == 0) ? r[0] : r[1]) win = s;
        end else begin
            for (int k = 0; k < NPORT; k++) begin
                p = (ref_ptr + k) % NPORT;
                if (win < 0 && ((p == 0) ? r[0] : r[1])) win = p;
            end
        end
        e_gnt  = (win < 0) ? 2'b00 : 2'(32'd1 << win);
        e_addr = (win < 0) ? 12'h000 : ((win == 0) ? a0 : a1);
        e_w    = (win < 0) ? 1'b0 : ((win == 0) ? w[0] : w[1]);
        e_wd   = (win >= 0 && e_w) ? ((win == 0) ? d0 : d1) : 8'h00;
        e_rv   = 2'b00;
        e_rd   = 16'h0000;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            e_rv = 2'(32'd1 << pend[0].port);
            e_rd = (pend[0].port == 0) ? {8'h00, pend[0].data} : {pend[0].data, 8'h00};
            void'(pend.pop_front());
        end
        chk({tag, "_gnt"},   32'(gnt),       32'(e_gnt));
        chk({tag, "_addr"},  32'(lbp_addr),  32'(e_addr));
        chk({tag, "_wen"},   32'(lbp_wen),   32'(e_w));
        chk({tag, "_ren"},   32'(lbp_ren),   32'((win >= 0) && !e_w));
        chk({tag, "_wdata"}, 32'(lbp_wdata), 32'(e_wd));
        chk({tag, "_rvalid"},32'(rvalid),    32'(e_rv));
        chk({tag, "_rdata"}, 32'(rdata),     32'(e_rd));
        chk({tag, "_ptr"},   32'(dut.ptr),   32'(ref_ptr));
        if (want_gnt >= 0) chk({tag, "_gnt_dir"}, 32'(gnt), want_gnt);
        if (want_rv >= 0)  chk({tag, "_rv_dir"},  32'(rvalid), want_rv);
        @(posedge clk);
        if (win >= 0) begin
            ref_ptr = (win + 1) % NPORT;
            if (e_w) ref_mem[e_addr] = e_wd;
            else     pend.push_back('{cyc + RD_LAT, win, ref_mem[e_addr]});
        end
        cyc++;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"},    32'(gnt),       32'd0);
        chk({tag, "_rvalid"}, 32'(rvalid),    32'd0);
        chk({tag, "_rdata"},  32'(rdata),     32'd0);
        chk({tag, "_addr"},   32'(lbp_addr),  32'd0);
        chk({tag, "_wen"},    32'(lbp_wen),   32'd0);
        chk({tag, "_ren"},    32'(lbp_ren),   32'd0);
        chk({tag, "_wdata"},  32'(lbp_wdata), 32'd0);
        chk({tag, "_ptr"},    32'(dut.ptr),   32'd0);
    endtask

    // Asynchronous reset mid-cycle with requests active; outputs must be 0.
    task automatic do_reset(input int hold, input string tag);
        #2;
        rst_n    = 1'b0;
        req      = 2'b11;
        wen      = 2'b00;
        arb_mode = 1'b1;
        #1;
        chk_zero({tag, "_in"});
        pend.delete();
        ref_ptr = 0;
        repeat (hold) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        chk_zero({tag, "_hold"});
        @(negedge clk);
        rst_n = 1'b1;
        req   = 2'b00;
        @(posedge clk);
        cyc++;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            bus_mem[i] = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        bus_mem[16] = 8'h3C;
        ref_mem[16] = 8'h3C;

        do_reset(2, "por");

        // Static write from port0 while port1 also requests.
        step(1'b0, 0, 2'b11, 2'b01, 12'h005, 12'h020, 8'hA5, 8'h00, "st_wr", 1, 0);
        // Static read from port1, returns 0x3C next cycle.
        step(1'b0, 1, 2'b10, 2'b00, 12'h000, 12'h010, 8'h00, 8'h00, "st_rd", 2, 0);
        step(1'b0, 1, 2'b00, 2'b00, 12'h000, 12'h000, 8'h00, 8'h00, "st_ret", 0, 2);

        // Round-robin, both ports reading, ptr starts at 0.
        step(1'b1, 0, 2'b11, 2'b00, 12'h005, 12'h010, 8'h00, 8'h00, "rr0", 1, 0);
        step(1'b1, 0, 2'b11, 2'b00, 12'h006, 12'h011, 8'h00, 8'h00, "rr1", 2, 1);
        step(1'b1, 0, 2'b11, 2'b00, 12'h007, 12'h012, 8'h00, 8'h00, "rr2", 1, 2);
        step(1'b1, 0, 2'b11, 2'b00, 12'h008, 12'h013, 8'h00, 8'h00, "rr3", 2, 1);
        step(1'b1, 0, 2'b00, 2'b00, 12'h000, 12'h000, 8'h00, 8'h00, "rr_end", 0, 2);

        // Single requester in round-robin; ptr returns to 0.
        step(1'b1, 0, 2'b10, 2'b00, 12'h000, 12'h030, 8'h00, 8'h00, "one0", 2, 0);
        step(1'b1, 0, 2'b10, 2'b00, 12'h000, 12'h031, 8'h00, 8'h00, "one1", 2, 2);
        step(1'b1, 0, 2'b10, 2'b00, 12'h000, 12'h032, 8'h00, 8'h00, "one2", 2, 2);

        // Read granted, then mode/sel flipped; return still goes to port0.
        step(1'b0, 0, 2'b01, 2'b00, 12'h040, 12'h000, 8'h00, 8'h00, "ms_rd", 1, 2);
        step(1'b1, 1, 2'b10, 2'b10, 12'h000, 12'h041, 8'h00, 8'h77, "ms_sw", 2, 1);

        // Reset while a read is in flight: no return afterwards.
        step(1'b1, 0, 2'b01, 2'b00, 12'h050, 12'h000, 8'h00, 8'h00, "rst_rd", 1, 0);
        do_reset(2, "midrd");
        step(1'b1, 0, 2'b00, 2'b00, 12'h000, 12'h000, 8'h00, 8'h00, "post0", 0, 0);
        step(1'b1, 0, 2'b11, 2'b00, 12'h051, 12'h052, 8'h00, 8'h00, "post1", 1, 0);

        // Randomized traffic on a small address window so writes get read back.
        for (int n = 0; n < 400; n++) begin
            step(1'(($urandom % 2)), int'($urandom % 2), 2'($urandom), 2'($urandom),
                 12'($urandom % 16), 12'($urandom % 16), 8'($urandom), 8'($urandom),
                 "rnd", -1, -1);
            if (n == 200) do_reset(1, "rndrst");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
